pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk and rst (rst low = reset, acts without a clk edge).
REQ-002 clk  in  1  pipeline clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 stallreq_id_i  in  1  ID-stage operand hazard request, level, valid every cycle.
REQ-005 ex_start_i  in  1  one-cycle pulse: EX begins a multi-cycle operation.
REQ-006 ex_cycles_i  in  6  total EX occupancy N of the operation, sampled with ex_start_i.
REQ-007 excp_i  in  1  one-cycle pulse: exception, flush the pipeline.
REQ-008 excp_pc_i  in  32  handler address, sampled with excp_i.
REQ-009 stall_o  out  6  per-stage hold: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
REQ-010 flush_o  out  1  registered one-cycle flush of all pipeline registers.
REQ-011 new_pc_o  out  32  registered redirect address, valid while flush_o=1.
REQ-012 busy_o  out  1  high while state is MULTI.
REQ-013 stall_cnt_o  out  32  stalled-cycle count (see Configuration).

Function
REQ-014 SHALL implement states RUN and MULTI, plus a 6-bit down-counter cnt.
REQ-015 stall_o SHALL be combinational from state and current inputs; flush_o, new_pc_o, state and cnt registered.
REQ-016 RUN, no requests: stall_o = 000000.
REQ-017 RUN, stallreq_id_i=1: stall_o = 000111 in that same cycle.
REQ-018 RUN, ex_start_i=1 with N>=2: stall_o = 001111 in that cycle; N=0 or N=1: no stall, no state change.
REQ-019 ex_start_i with N>=3: next state MULTI, cnt loaded N-3; N=2: stay RUN.
REQ-020 MULTI: stall_o = 001111; if cnt=0 next state RUN, else cnt decrements by 1.
REQ-021 Net effect: stall_o bit3 asserted for exactly N-1 consecutive cycles starting with the ex_start_i cycle.
REQ-022 Simultaneous stall sources SHALL OR together (001111 dominates 000111).
REQ-023 ex_start_i while in MULTI SHALL be ignored (protocol violation, no state change).
REQ-024 excp_i SHALL take priority in any state: stall_o = 000000 in that cycle; next cycle flush_o=1, new_pc_o=excp_pc_i; state RUN, cnt=0 (aborts any multi-cycle op).
REQ-025 flush_o SHALL drop after one cycle unless excp_i is asserted again; back-to-back excp_i gives back-to-back flushes with the latest address.
REQ-026 During a flush_o=1 cycle, stallreq_id_i and ex_start_i SHALL be ignored and stall_o = 000000.
REQ-027 new_pc_o SHALL hold its last value when flush_o=0.

Reset
REQ-028 While rst=0: state RUN, cnt 0, stall_o 000000, flush_o 0, new_pc_o 0, busy_o 0, stall_cnt_o 0.
REQ-029 Reset asserted mid-MULTI SHALL abandon the operation immediately; the first cycle after release behaves as RUN.

Configuration
REQ-030 Macro PIPE_CTRL_STALL_CNT_EN defined: stall_cnt_o increments each cycle stall_o != 0, saturating at 32'hFFFFFFFF, never cleared except by reset.
REQ-031 Macro not defined: no counter logic; stall_cnt_o tied to 32'h0.

Verification
REQ-032 RUN, stallreq_id_i high 2 cycles -> stall_o=000111 exactly those 2 cycles, busy_o=0.
REQ-033 ex_start_i with N=5 -> stall_o=001111 for 4 cycles (start + 3 MULTI), busy_o high 3 cycles, then 000000.
REQ-034 ex_start_i with N=1, then N=2 -> no stall; then exactly 1 stall cycle, busy_o never high.
REQ-035 N=10, excp_i with excp_pc_i=32'h0000_0180 on 3rd stalled cycle -> stall_o=000000 that cycle, flush_o=1 with new_pc_o=32'h0000_0180 next cycle, busy_o=0.
REQ-036 rst driven low mid-MULTI between clock edges -> all outputs 0 immediately; after release with no requests stall_o=000000.
REQ-037 With PIPE_CTRL_STALL_CNT_EN: scenarios REQ-032 then REQ-033 -> stall_cnt_o=6; without macro stall_cnt_o stays 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard/stall/flush controller.
// Drives per-stage holds for ID operand hazards and multi-cycle EX operations,
// and issues a registered one-cycle flush with redirect PC on exceptions.
// Optional stalled-cycle counter enabled by defining PIPE_CTRL_STALL_CNT_EN.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id_i,
  input  logic        ex_start_i,
  input  logic [5:0]  ex_cycles_i,
  input  logic        excp_i,
  input  logic [31:0] excp_pc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic {RUN, MULTI} state_t;

  // Hold patterns: ID hazard freezes pc/if/id; EX busy also freezes ex.
  localparam logic [5:0] STALL_ID = 6'b000111;
  localparam logic [5:0] STALL_EX = 6'b001111;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        flush_q;
  logic [31:0] new_pc_q;

  // State and down-counter register.
  // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and stall decode; exception wins, flush cycle ignores requests.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_o = 6'b000000;
    if (!rst) begin
      stall_o = 6'b000000;
    end else if (excp_i) begin
      state_d = RUN;
      cnt_d   = 6'd0;
    end else if (!flush_q) begin
      if (stallreq_id_i)
        stall_o = stall_o | STALL_ID;
      case (state_q)
        RUN: begin
          if (ex_start_i && ex_cycles_i >= 6'd2) begin
            stall_o = stall_o | STALL_EX;
            if (ex_cycles_i >= 6'd3) begin
              state_d = MULTI;
              cnt_d   = ex_cycles_i - 6'd3;
            end
          end
        end
        MULTI: begin
          stall_o = stall_o | STALL_EX;
          if (cnt_q == 6'd0)
            state_d = RUN;
          else
            cnt_d = cnt_q - 6'd1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Registered flush pulse and redirect address; address holds between flushes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_q  <= 1'b0;
      new_pc_q <= 32'h0;
    end else begin
      flush_q <= excp_i;
      if (excp_i)
        new_pc_q <= excp_pc_i;
    end
  end

  assign flush_o  = flush_q;
  assign new_pc_o = new_pc_q;
  assign busy_o   = (state_q == MULTI);

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles with any stage held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt_q <= 32'h0;
    else if (stall_o != 6'b000000 && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
// A remaining-EX-cycles model is checked every negedge; directed vectors
// carry hand-computed stall/busy/flush expectations.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_id_i = 1'b0;
  logic        ex_start_i = 1'b0;
  logic [5:0]  ex_cycles_i = 6'd0;
  logic        excp_i = 1'b0;
  logic [31:0] excp_pc_i = 32'h0;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;
  logic [31:0] stall_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .stallreq_id_i(stallreq_id_i), .ex_start_i(ex_start_i), .ex_cycles_i(ex_cycles_i),
    .excp_i(excp_i), .excp_pc_i(excp_pc_i),
    .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
    .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: how many more cycles the EX stage stays held after the current one.
  int          ex_left;
  bit          flush_m;
  logic [31:0] pc_m;
  logic [31:0] cnt_m;

  function automatic logic [5:0] model_stall();
    if (!rst || excp_i || flush_m) return 6'b000000;
    if (ex_left > 0 || (ex_start_i && ex_cycles_i >= 6'd2)) return 6'b001111;
    if (stallreq_id_i) return 6'b000111;
    return 6'b000000;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_left = 0; flush_m = 0; pc_m = 32'h0; cnt_m = 32'h0;
    end else begin
      bit was_fl;
      if (model_stall() != 6'b0 && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 1;
      was_fl  = flush_m;
      flush_m = excp_i;
      if (excp_i) begin
        pc_m = excp_pc_i;
        ex_left = 0;
      end else if (!was_fl) begin
        if (ex_left > 0) ex_left = ex_left - 1;
        else if (ex_start_i && ex_cycles_i >= 6'd2) ex_left = int'(ex_cycles_i) - 2;
      end
    end
  end

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin
    check("m_stall", {26'd0, stall_o}, {26'd0, model_stall()});
    check("m_busy", {31'd0, busy_o}, {31'd0, ex_left > 0});
    check("m_flush", {31'd0, flush_o}, {31'd0, flush_m});
    check("m_new_pc", new_pc_o, pc_m);
`ifdef PIPE_CTRL_STALL_CNT_EN
    check("m_stall_cnt", stall_cnt_o, cnt_m);
`else
    check("m_stall_cnt", stall_cnt_o, 32'h0);
`endif
  end

  // One directed cycle: drive inputs, check hand expectations mid-cycle.
  task automatic cyc(input bit sreq, input bit st, input logic [5:0] n, input bit ex,
                     input logic [31:0] pc, input logic [5:0] es, input bit eb, input bit ef);
    stallreq_id_i = sreq; ex_start_i = st; ex_cycles_i = n; excp_i = ex; excp_pc_i = pc;
    @(negedge clk);
    check("stall", {26'd0, stall_o}, {26'd0, es});
    check("busy", {31'd0, busy_o}, {31'd0, eb});
    check("flush", {31'd0, flush_o}, {31'd0, ef});
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic [5:0] es, input bit eb, input bit ef);
    cyc(0, 0, 6'd0, 0, 32'h0, es, eb, ef);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", {26'd0, stall_o}, 32'h0);
    check("rst_busy", {31'd0, busy_o}, 32'h0);
    check("rst_flush", {31'd0, flush_o}, 32'h0);
    check("rst_new_pc", new_pc_o, 32'h0);
    rst = 1'b1;
    idle(6'h00, 0, 0);

    // ID hazard two cycles.
    cyc(1, 0, 6'd0, 0, 32'h0, 6'h07, 0, 0);
    cyc(1, 0, 6'd0, 0, 32'h0, 6'h07, 0, 0);
    idle(6'h00, 0, 0);

    // N=5: 4 stall cycles, busy for the last 3.
    cyc(0, 1, 6'd5, 0, 32'h0, 6'h0F, 0, 0);
    idle(6'h0F, 1, 0);
    idle(6'h0F, 1, 0);
    idle(6'h0F, 1, 0);
    idle(6'h00, 0, 0);
`ifdef PIPE_CTRL_STALL_CNT_EN
    check("cnt_after_6", stall_cnt_o, 32'd6);
`else
    check("cnt_disabled", stall_cnt_o, 32'd0);
`endif

    // N=0, N=1 no stall; N=2 exactly one stall cycle.
    cyc(0, 1, 6'd0, 0, 32'h0, 6'h00, 0, 0);
    cyc(0, 1, 6'd1, 0, 32'h0, 6'h00, 0, 0);
    cyc(0, 1, 6'd2, 0, 32'h0, 6'h0F, 0, 0);
    idle(6'h00, 0, 0);

    // Sources OR together; N=3 gives one MULTI cycle.
    cyc(1, 1, 6'd3, 0, 32'h0, 6'h0F, 0, 0);
    cyc(1, 0, 6'd0, 0, 32'h0, 6'h0F, 1, 0);
    cyc(1, 0, 6'd0, 0, 32'h0, 6'h07, 0, 0);
    idle(6'h00, 0, 0);

    // ex_start while MULTI is ignored.
    cyc(0, 1, 6'd4, 0, 32'h0, 6'h0F, 0, 0);
    cyc(0, 1, 6'd20, 0, 32'h0, 6'h0F, 1, 0);
    idle(6'h0F, 1, 0);
    idle(6'h00, 0, 0);

    // N=10, exception on the 3rd stalled cycle; requests ignored during flush.
    cyc(0, 1, 6'd10, 0, 32'h0, 6'h0F, 0, 0);
    idle(6'h0F, 1, 0);
    cyc(0, 0, 6'd0, 1, 32'h0000_0180, 6'h00, 1, 0);
    cyc(1, 1, 6'd5, 0, 32'h0, 6'h00, 0, 1);
    check("flush_pc", new_pc_o, 32'h0000_0180);
    idle(6'h00, 0, 0);
    check("pc_hold", new_pc_o, 32'h0000_0180);

    // Back-to-back exceptions: latest address wins.
    cyc(0, 0, 6'd0, 1, 32'h0000_1000, 6'h00, 0, 0);
    cyc(0, 0, 6'd0, 1, 32'h0000_2000, 6'h00, 0, 1);
    idle(6'h00, 0, 1);
    check("b2b_pc", new_pc_o, 32'h0000_2000);
    idle(6'h00, 0, 0);

    // Asynchronous reset mid-MULTI.
    cyc(0, 1, 6'd8, 0, 32'h0, 6'h0F, 0, 0);
    idle(6'h0F, 1, 0);
    #2 rst = 1'b0;
    #1;
    check("arst_stall", {26'd0, stall_o}, 32'h0);
    check("arst_busy", {31'd0, busy_o}, 32'h0);
    check("arst_flush", {31'd0, flush_o}, 32'h0);
    check("arst_new_pc", new_pc_o, 32'h0);
    check("arst_cnt", stall_cnt_o, 32'h0);
    @(posedge clk); #1;
    idle(6'h00, 0, 0);
    rst = 1'b1;
    idle(6'h00, 0, 0);
    idle(6'h00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
